dfe2dp_rd_sched: RTL and testbench
==================================

// Module: dfe2dp_rd_sched
// PURPOSE
//  Read-side scheduler for the DFE->datapath CDC RAM pair, in the 245.76 MHz domain. Locks onto the
//  external frame head with a SEARCH/VERIFY/LOCKED flywheel FSM and owns the RAM read address.
//  Emits per-path frame and xant strobes aligned to RAM read latency; bandwidth-mode changes apply only at frame boundaries.
// PARAMETERS
//  ADDR_W    4        read address width per path (2^ADDR_W-entry read cycle)
//  FRAM_MAX  2457599  frame length in clk_245p76 cycles minus 1
//  LOCK_CNT  3        consecutive on-slot heads needed to reach LOCKED (>=1)
//  MISS_MAX  2        consecutive missed slots in LOCKED before drop to SEARCH (>=1)
//  PIPE_DLY  3        cycles from internal head to o_path_fram (RAM + register latency, >=1)
// PORTS
//  clk_245p76          in   1         clock
//  rst_245p76          in   1         synchronous reset, active-high
//  i_en                in   1         scheduler enable; 0 forces IDLE
//  i_ext_hd            in   1         external frame head, 1-cycle pulse (already synchronised)
//  i_bandwidth_nr_mod  in   3         NR bandwidth code: 2=20M 3=30M 4=40M 5=50M 6=60M
//  o_p0_addr           out  ADDR_W+1  path0 RAM read addr {a[ADDR_W-1:2],1'b0,a[1:0]}
//  o_p1_addr           out  ADDR_W+1  path1 RAM read addr {a[ADDR_W-1:2],1'b1,a[1:0]}
//  o_path_fram         out  1         frame strobe shared by both paths (delayed head)
//  o_path0_xant        out  1         path0 antenna strobe
//  o_path1_xant        out  1         path1 antenna strobe
//  o_mod_sel           out  1         active mode: 0=20/30M (xant every 8), 1=others (every 4)
//  o_locked            out  1         FSM in LOCKED
//  o_state             out  2         0=IDLE 1=SEARCH 2=VERIFY 3=LOCKED
//  o_err_cnt           out  8         off-slot heads seen in LOCKED (saturating)
//  o_miss_cnt          out  8         missed slots seen in LOCKED (saturating)
// BEHAVIOUR
//  - Reset: state IDLE, fcnt=0, a=0, all outputs 0. rst_245p76 has priority over everything.
//  - fcnt: 0..FRAM_MAX wrap, runs in VERIFY/LOCKED. Ext head at cycle t -> fcnt=0 at t+1.
//    "Slot" = cycle with fcnt==FRAM_MAX; on-slot head = i_ext_hd in a slot cycle.
//  - IDLE: i_en=1 -> SEARCH. i_en=0 in any state -> IDLE next cycle; strobes 0, a=0, counters held.
//  - SEARCH: i_ext_hd -> VERIFY, good=1 (if LOCK_CNT==1 go LOCKED directly).
//  - VERIFY: on-slot head -> good+1, LOCKED when good==LOCK_CNT. Off-slot head -> stay VERIFY,
//    re-seed fcnt from it, good=1. Slot without head -> SEARCH.
//  - LOCKED: flywheels. On-slot head clears miss run; off-slot head ignored, err_cnt+1;
//    slot without head -> miss run+1, miss_cnt+1; run==MISS_MAX -> SEARCH, o_locked=0 next cycle.
//  - Internal head ihd: 1 cycle when fcnt==0 in LOCKED only (incl. first cycle after entering LOCKED).
//  - a (read addr): 0 on ihd cycle, else a+1 mod 2^ADDR_W; frozen at 0 outside LOCKED.
//  - o_mod_sel: code 2,3 ->0; 4,5,6 and all others ->1. Sampled only on ihd; input changes
//    mid-frame take effect at the next ihd. Reset value 1.
//  - o_path_fram = ihd delayed PIPE_DLY cycles. aux_cnt (4b): 0 on that delayed cycle, else +1 wrap.
//    xant (both paths, one cycle after aux_cnt) = o_mod_sel ? aux_cnt[1:0]==3 : aux_cnt[2:0]==7.
//    Delay line flushed on leaving LOCKED: no fram/xant strobes outside LOCKED.
//  - Simultaneous: i_en fall beats any head; on-slot head and MISS_MAX decision same cycle -> head wins.
//  - Counters saturate at 255, clear on reset only.
// CONFIGURATION
//  DFE2DP_RD_SCHED_STAT_EN defined: o_err_cnt / o_miss_cnt implemented as above.
//  Not defined: no counter logic; both ports tied to 8'd0; FSM behaviour identical.
// TESTING (sim with FRAM_MAX=99, LOCK_CNT=3, MISS_MAX=2, PIPE_DLY=3)
//  1. Heads every 100 cycles from t=10, i_en=1 -> o_state 1->2 at t=11, LOCKED after head at t=210;
//     o_path_fram every 100 cycles, 3 cycles after fcnt==0; o_p0_addr 0,1,2,3,8,9.. / o_p1_addr 4,5,6,7,12..
//  2. Locked, mode=2 -> xant every 8 cycles; mode->5 mid-frame -> spacing 4 only after next o_path_fram.
//  3. Locked, drop one head -> stays LOCKED, miss_cnt=1; drop two consecutive -> SEARCH, strobes stop.
//  4. Locked, extra head at fcnt=40 -> timing unchanged, err_cnt=1; in VERIFY same -> fcnt re-seeded, good=1.
//  5. i_en=0 for 1 cycle while locked -> IDLE, a=0, no strobes; i_en=1 -> re-search, relock after 3 heads.
//  6. rst_245p76 mid-frame -> all outputs 0, o_mod_sel=1, o_state=0; build without STAT_EN -> counters 0.

Source files
------------

// File: rtl/dfe2dp_rd_sched.sv
// -----------------------------------------------------------------------------
// dfe2dp_rd_sched
// Read-side scheduler for the DFE->datapath CDC RAM pair (245.76 MHz domain).
// A SEARCH/VERIFY/LOCKED flywheel FSM locks onto the external frame head and
// owns the shared RAM read address. Per-path frame/antenna strobes are delayed
// to line up with the RAM read latency. The bandwidth mode is sampled only on
// the internal frame head, so mode changes always land on a frame boundary.
//
// Optional build macro: DFE2DP_RD_SCHED_STAT_EN
//   defined     -> o_err_cnt / o_miss_cnt are saturating event counters
//   not defined -> no counter logic, both ports read 8'd0
//
// Ports
//   clk_245p76          in   clock
//   rst_245p76          in   synchronous reset, active-high
//   i_en                in   scheduler enable (0 forces IDLE)
//   i_ext_hd            in   external frame head, 1-cycle pulse
//   i_bandwidth_nr_mod  in   NR bandwidth code (2..6 = 20M..60M)
//   o_p0_addr           out  path0 RAM read address {a[hi:2],0,a[1:0]}
//   o_p1_addr           out  path1 RAM read address {a[hi:2],1,a[1:0]}
//   o_path_fram         out  frame strobe shared by both paths
//   o_path0_xant        out  path0 antenna strobe
//   o_path1_xant        out  path1 antenna strobe
//   o_mod_sel           out  active mode: 0 = xant every 8, 1 = every 4
//   o_locked            out  FSM in LOCKED
//   o_state             out  0=IDLE 1=SEARCH 2=VERIFY 3=LOCKED
//   o_err_cnt           out  off-slot heads seen in LOCKED (saturating)
//   o_miss_cnt          out  missed slots seen in LOCKED (saturating)
//
// ADDR_W must be >= 3 so the path-select bit can be spliced in at bit 2.
// -----------------------------------------------------------------------------
module dfe2dp_rd_sched #(
    parameter int ADDR_W   = 4,
    parameter int FRAM_MAX = 2457599,
    parameter int LOCK_CNT = 3,
    parameter int MISS_MAX = 2,
    parameter int PIPE_DLY = 3
) (
    input  logic              clk_245p76,
    input  logic              rst_245p76,
    input  logic              i_en,
    input  logic              i_ext_hd,
    input  logic [2:0]        i_bandwidth_nr_mod,
    output logic [ADDR_W:0]   o_p0_addr,
    output logic [ADDR_W:0]   o_p1_addr,
    output logic              o_path_fram,
    output logic              o_path0_xant,
    output logic              o_path1_xant,
    output logic              o_mod_sel,
    output logic              o_locked,
    output logic [1:0]        o_state,
    output logic [7:0]        o_err_cnt,
    output logic [7:0]        o_miss_cnt
);

    localparam int FCNT_W = $clog2(FRAM_MAX + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int RUN_W  = $clog2(MISS_MAX + 1);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAM_MAX);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  RUN_DROP  = RUN_W'(MISS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // 20M/30M use the 8-cycle antenna cadence, everything else the 4-cycle one.
    function automatic logic mode_sel_of(input logic [2:0] code);
        logic sel;
        case (code)
            3'd2, 3'd3: sel = 1'b0;
            default:    sel = 1'b1;
        endcase
        return sel;
    endfunction

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d, fcnt_inc;
    logic [GOOD_W-1:0]   good_q, good_d, good_inc;
    logic [RUN_W-1:0]    run_q, run_d, run_inc;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic                mod_sel_q, mod_sel_d;
    logic [PIPE_DLY-1:0] dly_q, dly_d;
    logic [3:0]          aux_q, aux_d;
    logic                xant_q, xant_d;
    logic                slot, ihd;

    assign slot     = (fcnt_q == FCNT_LAST);
    assign fcnt_inc = slot ? '0 : fcnt_q + FCNT_W'(1);
    assign good_inc = good_q + GOOD_W'(1);
    assign run_inc  = run_q + RUN_W'(1);

    // Internal head: frame start as seen by the flywheel, only while locked.
    assign ihd = (state_q == ST_LOCKED) && (fcnt_q == '0);

    // Lock FSM and frame counter. Losing i_en beats any head; an on-slot head
    // in LOCKED clears the miss run before the drop decision is taken.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        good_d  = good_q;
        run_d   = run_q;
        if (!i_en) begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
            good_d  = '0;
            run_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                    fcnt_d  = '0;
                end
                ST_SEARCH: begin
                    fcnt_d = '0;
                    if (i_ext_hd) begin
                        good_d  = GOOD_W'(1);
                        run_d   = '0;
                        state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    fcnt_d = fcnt_inc;
                    if (i_ext_hd && slot) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_LOCK) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end
                    end else if (i_ext_hd) begin
                        // Off-slot head: restart verification from this head.
                        fcnt_d = '0;
                        good_d = GOOD_W'(1);
                    end else if (slot) begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: off-slot heads never move the frame timing.
                    fcnt_d = fcnt_inc;
                    if (slot) begin
                        if (i_ext_hd) begin
                            run_d = '0;
                        end else begin
                            run_d = run_inc;
                            if (run_inc == RUN_DROP) begin
                                state_d = ST_SEARCH;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Read address restarts so that it is 0 exactly on the ihd cycle.
    assign a_d       = ((state_d == ST_LOCKED) && (fcnt_d != '0)) ? a_q + ADDR_W'(1) : '0;
    assign mod_sel_d = ihd ? mode_sel_of(i_bandwidth_nr_mod) : mod_sel_q;

    // Strobe delay line is flushed as soon as LOCKED is left.
    assign dly_d  = (state_d == ST_LOCKED) ? ((dly_q << 1) | PIPE_DLY'(ihd)) : '0;
    assign aux_d  = ((state_q != ST_LOCKED) || dly_d[PIPE_DLY-1]) ? 4'd0 : aux_q + 4'd1;
    assign xant_d = (state_d == ST_LOCKED) &&
                    (mod_sel_q ? ((aux_q & 4'h3) == 4'h3) : ((aux_q & 4'h7) == 4'h7));

    // Stage p0: FSM, frame counter, address and mode registers
    always_ff @(posedge clk_245p76) begin
        if (rst_245p76) begin
            state_q   <= ST_IDLE;
            fcnt_q    <= '0;
            good_q    <= '0;
            run_q     <= '0;
            a_q       <= '0;
            mod_sel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            good_q    <= good_d;
            run_q     <= run_d;
            a_q       <= a_d;
            mod_sel_q <= mod_sel_d;
        end
    end

    // Stage p1..pN: RAM-latency delay line and antenna strobe generation
    always_ff @(posedge clk_245p76) begin
        if (rst_245p76) begin
            dly_q  <= '0;
            aux_q  <= '0;
            xant_q <= 1'b0;
        end else begin
            dly_q  <= dly_d;
            aux_q  <= aux_d;
            xant_q <= xant_d;
        end
    end

    assign o_p0_addr    = {a_q[ADDR_W-1:2], 1'b0, a_q[1:0]};
    assign o_p1_addr    = {a_q[ADDR_W-1:2], 1'b1, a_q[1:0]};
    assign o_path_fram  = dly_q[PIPE_DLY-1];
    assign o_path0_xant = xant_q;
    assign o_path1_xant = xant_q;
    assign o_mod_sel    = mod_sel_q;
    assign o_locked     = (state_q == ST_LOCKED);
    assign o_state      = state_q;

`ifdef DFE2DP_RD_SCHED_STAT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       hd_off_lk, miss_lk;
    logic [7:0] err_q, err_d, miss_q, miss_d;

    assign hd_off_lk = i_en && (state_q == ST_LOCKED) && i_ext_hd && !slot;
    assign miss_lk   = i_en && (state_q == ST_LOCKED) && slot && !i_ext_hd;
    assign err_d     = hd_off_lk ? sat_inc8(err_q) : err_q;
    assign miss_d    = miss_lk ? sat_inc8(miss_q) : miss_q;

    always_ff @(posedge clk_245p76) begin
        if (rst_245p76) begin
            err_q  <= '0;
            miss_q <= '0;
        end else begin
            err_q  <= err_d;
            miss_q <= miss_d;
        end
    end

    assign o_err_cnt  = err_q;
    assign o_miss_cnt = miss_q;
`else
    assign o_err_cnt  = 8'd0;
    assign o_miss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dfe2dp_rd_sched.sv
// -----------------------------------------------------------------------------
// tb_dfe2dp_rd_sched
// Directed bench for dfe2dp_rd_sched with FRAM_MAX=99, LOCK_CNT=3, MISS_MAX=2,
// PIPE_DLY=3. Expected o_path_fram cycles are queued when the heads that
// cause them are driven and are checked by a monitor when the strobe appears.
// -----------------------------------------------------------------------------
module tb_dfe2dp_rd_sched;

    localparam int ADDR_W   = 4;
    localparam int FRAM_MAX = 99;
    localparam int LOCK_CNT = 3;
    localparam int MISS_MAX = 2;
    localparam int PIPE_DLY = 3;
`ifdef DFE2DP_RD_SCHED_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              hd;
    logic [2:0]        mode;
    logic [ADDR_W:0]   p0_addr;
    logic [ADDR_W:0]   p1_addr;
    logic              fram;
    logic              xant0;
    logic              xant1;
    logic              mod_sel;
    logic              locked;
    logic [1:0]        state;
    logic [7:0]        err_cnt;
    logic [7:0]        miss_cnt;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int sb[$];

    dfe2dp_rd_sched #(
        .ADDR_W  (ADDR_W),
        .FRAM_MAX(FRAM_MAX),
        .LOCK_CNT(LOCK_CNT),
        .MISS_MAX(MISS_MAX),
        .PIPE_DLY(PIPE_DLY)
    ) dut (
        .clk_245p76        (clk),
        .rst_245p76        (rst),
        .i_en              (en),
        .i_ext_hd          (hd),
        .i_bandwidth_nr_mod(mode),
        .o_p0_addr         (p0_addr),
        .o_p1_addr         (p1_addr),
        .o_path_fram       (fram),
        .o_path0_xant      (xant0),
        .o_path1_xant      (xant1),
        .o_mod_sel         (mod_sel),
        .o_locked          (locked),
        .o_state           (state),
        .o_err_cnt         (err_cnt),
        .o_miss_cnt        (miss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        if (cyc > t) chk("schedule", cyc, t);
        while (cyc < t) tick();
    endtask

    task automatic pulse_at(input int t);
        wait_until(t);
        hd = 1'b1;
        tick();
        hd = 1'b0;
    endtask

    // Frame strobe scoreboard
    always @(negedge clk) begin
        if (fram === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL fram_unexpected observed=strobe@%0d expected=none", cyc);
            end
            if (sb.size() != 0) chk("fram_cycle", cyc, sb.pop_front());
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int b, h0, h2, h3, h4, h5, h6, h7, h8, j0, k0, e, l0;
        int f2, f3, f4;
        int exp_p0[6] = '{0, 1, 2, 3, 8, 9};
        int exp_p1[6] = '{4, 5, 6, 7, 12, 13};

        rst  = 1'b1;
        en   = 1'b0;
        hd   = 1'b0;
        mode = 3'd2;
        repeat (3) tick();
        chk("rst_state",   state,    0);
        chk("rst_locked",  locked,   0);
        chk("rst_fram",    fram,     0);
        chk("rst_xant0",   xant0,    0);
        chk("rst_xant1",   xant1,    0);
        chk("rst_mod_sel", mod_sel,  1);
        chk("rst_p0_addr", p0_addr,  0);
        chk("rst_err",     err_cnt,  0);
        chk("rst_miss",    miss_cnt, 0);

        // reset dominates i_en
        en = 1'b1;
        tick();
        chk("rst_prio_state", state, 0);
        rst = 1'b0;
        b = cyc;
        tick();
        chk("search_entry", state, 1);

        // 1. acquisition: heads every 100 cycles
        h0 = b + 10;
        wait_until(h0);
        chk("search_before_head", state, 1);
        pulse_at(h0);
        chk("verify_after_head", state, 2);
        pulse_at(h0 + 100);
        chk("verify_good2", state, 2);
        h2 = h0 + 200;
        sb.push_back(h2 + 1 + PIPE_DLY);
        pulse_at(h2);
        chk("locked_state", state, 3);
        chk("locked_flag", locked, 1);
        chk("mod_sel_before_ihd", mod_sel, 1);
        for (int i = 0; i < 6; i++) begin
            wait_until(h2 + 1 + i);
            chk("p0_addr_seq", p0_addr, exp_p0[i]);
            chk("p1_addr_seq", p1_addr, exp_p1[i]);
            if (i == 1) chk("mod_sel_mode2", mod_sel, 0);
        end

        // 2. mode 2 -> xant every 8, mode change only at next frame
        f2 = h2 + 1 + PIPE_DLY;
        wait_until(f2 + 4); chk("m0_x4_quiet", xant0, 0);
        wait_until(f2 + 7); chk("m0_x7_quiet", xant0, 0);
        wait_until(f2 + 8); chk("m0_x8_p0", xant0, 1); chk("m0_x8_p1", xant1, 1);

        h3 = h2 + 100;
        f3 = h3 + 1 + PIPE_DLY;
        sb.push_back(f3);
        pulse_at(h3);
        wait_until(h3 + 50);
        mode = 3'd5;
        wait_until(f3 + 52); chk("midframe_still8_quiet", xant0, 0);
        wait_until(f3 + 56); chk("midframe_still8_hit", xant0, 1);

        h4 = h3 + 100;
        f4 = h4 + 1 + PIPE_DLY;
        sb.push_back(f4);
        pulse_at(h4);
        chk("mod_sel_on_ihd", mod_sel, 0);
        tick();
        chk("mod_sel_after_ihd", mod_sel, 1);
        wait_until(f4 + 2); chk("m1_x2_quiet", xant0, 0);
        wait_until(f4 + 4); chk("m1_x4_hit", xant0, 1);
        wait_until(f4 + 6); chk("m1_x6_quiet", xant0, 0);
        wait_until(f4 + 8); chk("m1_x8_p0", xant0, 1); chk("m1_x8_p1", xant1, 1);

        // 3. missed heads
        h5 = h4 + 100;
        sb.push_back(h5 + 1 + PIPE_DLY);
        wait_until(h5 + 1);
        chk("miss1_locked", state, 3);
        chk("miss1_cnt", miss_cnt, STAT * 1);
        h6 = h5 + 100;
        sb.push_back(h6 + 1 + PIPE_DLY);
        pulse_at(h6);
        chk("recover_locked", state, 3);
        h7 = h6 + 100;
        sb.push_back(h7 + 1 + PIPE_DLY);
        wait_until(h7 + 1);
        chk("miss2_locked", state, 3);
        chk("miss2_cnt", miss_cnt, STAT * 2);
        h8 = h7 + 100;
        wait_until(h8 + 1);
        chk("drop_state", state, 1);
        chk("drop_locked", locked, 0);
        chk("drop_addr", p0_addr, 0);
        chk("drop_miss_cnt", miss_cnt, STAT * 3);
        wait_until(h8 + 4);
        chk("drop_xant", xant0, 0);
        chk("drop_fram", fram, 0);

        // 4. off-slot heads in VERIFY and LOCKED
        j0 = h8 + 30;
        pulse_at(j0);
        chk("reacq_verify", state, 2);
        pulse_at(j0 + 40);
        chk("verify_offslot_stay", state, 2);
        wait_until(j0 + 101);
        chk("verify_reseeded", state, 2);
        pulse_at(j0 + 140);
        chk("verify_good2_b", state, 2);
        k0 = j0 + 240;
        sb.push_back(k0 + 1 + PIPE_DLY);
        pulse_at(k0);
        chk("relock_b", state, 3);
        pulse_at(k0 + 41);
        chk("locked_offslot_state", state, 3);
        chk("locked_offslot_err", err_cnt, STAT * 1);
        sb.push_back(k0 + 101 + PIPE_DLY);
        pulse_at(k0 + 100);
        chk("locked_after_offslot", state, 3);

        // 5. one-cycle enable drop, coincident with a head
        e = k0 + 150;
        wait_until(e);
        en = 1'b0;
        hd = 1'b1;
        tick();
        en = 1'b1;
        hd = 1'b0;
        chk("en_drop_state", state, 0);
        chk("en_drop_locked", locked, 0);
        chk("en_drop_p0", p0_addr, 0);
        chk("en_drop_p1", p1_addr, 4);
        chk("en_drop_err_held", err_cnt, STAT * 1);
        tick();
        chk("en_resume_search", state, 1);
        chk("en_resume_xant", xant0, 0);
        l0 = e + 20;
        pulse_at(l0);
        pulse_at(l0 + 100);
        sb.push_back(l0 + 201 + PIPE_DLY);
        pulse_at(l0 + 200);
        chk("relock_c", state, 3);
        wait_until(l0 + 230);
        chk("sb_drained", sb.size(), 0);

        // 6. reset mid-frame
        wait_until(l0 + 250);
        rst = 1'b1;
        tick();
        chk("rst2_state",   state,    0);
        chk("rst2_locked",  locked,   0);
        chk("rst2_fram",    fram,     0);
        chk("rst2_xant",    xant0,    0);
        chk("rst2_mod_sel", mod_sel,  1);
        chk("rst2_p0_addr", p0_addr,  0);
        chk("rst2_err",     err_cnt,  0);
        chk("rst2_miss",    miss_cnt, 0);
        rst = 1'b0;
        en  = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
